priority_select_pipe: RTL



---
 rtl/priority_select_pipe.sv | 134 +++++++++++++
 1 files changed

// File: rtl/priority_select_pipe.sv
// Priority-encoded operand select feeding a 2-entry output skid buffer.
// Optional feature: define SELMUX_LOCK_EN to add the lock port and locked_idx register.
module priority_select_pipe #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 3,
    localparam int IDXW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-2:0]       in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
`ifdef SELMUX_LOCK_EN
    input  logic                      lock,
`endif
    output logic [WIDTH-1:0]          out_data,
    output logic [IDXW-1:0]           out_idx,
    output logic                      out_valid,
    input  logic                      out_ready
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state, state_nxt;
    logic              push, pop;
    logic              load_head_new, load_head_skid, load_skid;
    logic [IDXW-1:0]   pri_idx, sel_idx;
    logic [WIDTH-1:0]  sel_data;
    logic [WIDTH-1:0]  skid_data;
    logic [IDXW-1:0]   skid_idx;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Highest set control bit wins; later loop iterations override earlier ones.
    always_comb begin
        pri_idx = '0;
        for (int j = 1; j < CHANNELS; j++) begin
            if (in_sel[j-1]) pri_idx = IDXW'(j);
        end
    end

`ifdef SELMUX_LOCK_EN
    logic [IDXW-1:0] locked_idx;

    always_ff @(posedge clk) begin
        if (!rst_n)              locked_idx <= '0;
        else if (push && !lock)  locked_idx <= pri_idx;
    end

    assign sel_idx = lock ? locked_idx : pri_idx;
`else
    assign sel_idx = pri_idx;
`endif

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (IDXW'(k) == sel_idx) sel_data = in_data[k*WIDTH +: WIDTH];
        end
    end

    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        load_head_new  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt     = ONE;
                    load_head_new = 1'b1;
                end
            end
            ONE: begin
                case ({push, pop})
                    2'b10: begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end
                    2'b01:   state_nxt     = EMPTY;
                    2'b11:   load_head_new = 1'b1;
                    default: state_nxt     = ONE;
                endcase
            end
            TWO: begin
                if (pop) begin
                    state_nxt      = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // Handshake flags come from the next state, keeping in_ready free of any out_ready path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            in_ready  <= (state_nxt != TWO);
        end
    end

    // NOTE: the data registers are reset too, because the head must read zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_idx   <= '0;
            skid_data <= '0;
            skid_idx  <= '0;
        end else begin
            if (load_head_new) begin
                out_data <= sel_data;
                out_idx  <= sel_idx;
            end else if (load_head_skid) begin
                out_data <= skid_data;
                out_idx  <= skid_idx;
            end
            if (load_skid) begin
                skid_data <= sel_data;
                skid_idx  <= sel_idx;
            end
        end
    end

endmodule
